// File: rtl/vvmac_pipe_if.sv
// Handshake/bus bundle for vvmac_pipe.
// The master side drives operands and consumes results; the slave side is the MAC pipeline.
// Optional macro VVMAC_SAT_EN adds the sat result flag.
interface vvmac_pipe_if #(
   parameter int VECTOR_SIZE = 16,
   parameter int INT_SIZE    = 16,
   parameter int ACC_SIZE    = 40
);
   logic                                   in_valid;
   logic                                   in_ready;
   logic                                   mode;
   logic                                   acc_clear;
   logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]   a;
   logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]   x;
   logic                                   out_valid;
   logic                                   out_ready;
   logic                                   out_mode;
   logic [VECTOR_SIZE-1:0][INT_SIZE-1:0]   y;
   logic [ACC_SIZE-1:0]                    dot;
`ifdef VVMAC_SAT_EN
   logic                                   sat;
`endif

   modport master (
      output in_valid, mode, acc_clear, a, x, out_ready,
      input  in_ready, out_valid, out_mode, y, dot
`ifdef VVMAC_SAT_EN
      , input sat
`endif
   );

   modport slave (
      input  in_valid, mode, acc_clear, a, x, out_ready,
      output in_ready, out_valid, out_mode, y, dot
`ifdef VVMAC_SAT_EN
      , output sat
`endif
   );
endinterface

// File: rtl/vvmac_pipe.sv
// vvmac_pipe: two-stage pipelined vector-vector multiplier with a runtime
// choice between element-wise multiply (mode 0) and dot-product accumulate (mode 1).
// Stage 1 registers full-width lane products; stage 2 truncates them or reduces
// them into the accumulator. valid/ready on both sides, with backpressure.
// Optional macro VVMAC_SAT_EN: saturate lanes and accumulator instead of
// truncating/wrapping, and report clamping on the sat output.
module vvmac_pipe #(
   parameter int VECTOR_SIZE = 16,
   parameter int INT_SIZE    = 16,
   parameter int ACC_SIZE    = 40
) (
   input  logic         clock,
   input  logic         reset,
   vvmac_pipe_if.slave  bus
);
   localparam int PW = 2 * INT_SIZE;

   typedef logic [VECTOR_SIZE-1:0][PW-1:0]       prod_t;
   typedef logic [VECTOR_SIZE-1:0][INT_SIZE-1:0] vec_t;

   // stage 1
   logic                s1_valid_q;
   logic                s1_mode_q;
   logic                s1_clr_q;
   prod_t               s1_prod_q;
   prod_t               prod_d;

   // stage 2 / outputs
   logic                out_valid_q;
   logic                out_mode_q;
   vec_t                y_q, y_d;
   logic [ACC_SIZE-1:0] dot_q, dot_d;
   logic [ACC_SIZE-1:0] acc_q, acc_d;
   logic [ACC_SIZE-1:0] sum_s;
`ifdef VVMAC_SAT_EN
   logic [ACC_SIZE:0]   acc_add_s;
   logic                sat_q, sat_d;
`endif

   logic                adv1_s;
   logic                adv2_s;

   // Pipeline advance: stage 2 moves when its slot is free or being drained,
   // stage 1 moves when empty or emptying into stage 2.
   always_comb begin
      adv2_s = s1_valid_q & (~out_valid_q | bus.out_ready);
      adv1_s = ~s1_valid_q | adv2_s;
   end

   assign bus.in_ready  = adv1_s;
   assign bus.out_valid = out_valid_q;
   assign bus.out_mode  = out_mode_q;
   assign bus.y         = y_q;
   assign bus.dot       = dot_q;
`ifdef VVMAC_SAT_EN
   assign bus.sat       = sat_q;
`endif

   // Full-width unsigned lane products of the incoming beat.
   always_comb begin
      prod_d = '0;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
         prod_d[i] = PW'(bus.a[i]) * PW'(bus.x[i]);
      end
   end

   // Stage 1 register: takes a new beat (or a bubble) whenever it may advance.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_clr_q   <= 1'b0;
         s1_prod_q  <= '0;
      end else if (adv1_s) begin
         s1_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            s1_mode_q <= bus.mode;
            s1_clr_q  <= bus.acc_clear;
            s1_prod_q <= prod_d;
         end
      end
   end

   // Stage 2 result: truncated/saturated lanes for mode 0, reduced and
   // accumulated sum for mode 1; the accumulator is untouched by mode 0 beats.
   always_comb begin
      sum_s = '0;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
         sum_s = sum_s + ACC_SIZE'(s1_prod_q[i]);
      end
      y_d   = '0;
      dot_d = '0;
      acc_d = acc_q;
`ifdef VVMAC_SAT_EN
      sat_d     = 1'b0;
      acc_add_s = {1'b0, acc_q} + {1'b0, sum_s};
`endif
      case (s1_mode_q)
         1'b0: begin
            for (int i = 0; i < VECTOR_SIZE; i++) begin
`ifdef VVMAC_SAT_EN
               if (|s1_prod_q[i][PW-1:INT_SIZE]) begin
                  y_d[i] = '1;
                  sat_d  = 1'b1;
               end else begin
                  y_d[i] = s1_prod_q[i][INT_SIZE-1:0];
               end
`else
               y_d[i] = s1_prod_q[i][INT_SIZE-1:0];
`endif
            end
         end
         1'b1: begin
            if (s1_clr_q) begin
               acc_d = sum_s;
            end else begin
`ifdef VVMAC_SAT_EN
               if (acc_add_s[ACC_SIZE]) begin
                  acc_d = '1;
                  sat_d = 1'b1;
               end else begin
                  acc_d = acc_add_s[ACC_SIZE-1:0];
               end
`else
               acc_d = acc_q + sum_s;
`endif
            end
            dot_d = acc_d;
         end
         default: begin
            acc_d = acc_q;
         end
      endcase
   end

   // Stage 2 / output register: loads on advance, holds while stalled,
   // and drops valid once the consumer has taken the beat.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_mode_q  <= 1'b0;
         y_q         <= '0;
         dot_q       <= '0;
         acc_q       <= '0;
`ifdef VVMAC_SAT_EN
         sat_q       <= 1'b0;
`endif
      end else if (adv2_s) begin
         out_valid_q <= 1'b1;
         out_mode_q  <= s1_mode_q;
         y_q         <= y_d;
         dot_q       <= dot_d;
         acc_q       <= acc_d;
`ifdef VVMAC_SAT_EN
         sat_q       <= sat_d;
`endif
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_vvmac_pipe.sv
// Self-checking bench for vvmac_pipe: stimulus queue, reference model feeding
// an expected-result scoreboard, and observed-result queue compared per test.
// Build with +define+VVMAC_SAT_EN to exercise the saturating variant.
module tb_vvmac_pipe;
   localparam int V = 16;
   localparam int I = 16;
   localparam int A = 40;

   typedef logic [V-1:0][I-1:0] vec_t;
   typedef struct { logic mode; logic clr; vec_t a; vec_t x; } beat_t;
   typedef struct { logic mode; vec_t y; logic [A-1:0] dot; logic sat; int cyc; } res_t;

   logic clk;
   logic rst;

   vvmac_pipe_if #(.VECTOR_SIZE(V), .INT_SIZE(I), .ACC_SIZE(A)) bif ();

   vvmac_pipe #(.VECTOR_SIZE(V), .INT_SIZE(I), .ACC_SIZE(A)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   beat_t        stim_q[$];
   res_t         exp_q[$];
   res_t         obs_q[$];
   logic [A-1:0] model_acc;
   int           cyc;
   int           checks;
   int           errors;
   int           accepted;

   function automatic res_t predict(input beat_t b, input logic [A-1:0] acc);
      res_t           r;
      logic [2*I-1:0] p;
      logic [A:0]     s;
      logic [A:0]     n;
      r.mode = b.mode;
      r.y    = '0;
      r.dot  = '0;
      r.sat  = 1'b0;
      r.cyc  = 0;
      s      = '0;
      for (int i = 0; i < V; i++) begin
         p = {{I{1'b0}}, b.a[i]} * {{I{1'b0}}, b.x[i]};
         s = s + {{(A+1-2*I){1'b0}}, p};
         if (!b.mode) begin
            r.y[i] = p[I-1:0];
`ifdef VVMAC_SAT_EN
            if (p > 32'd65535) begin
               r.y[i] = 16'hFFFF;
               r.sat  = 1'b1;
            end
`endif
         end
      end
      if (b.mode) begin
         n = b.clr ? s : ({1'b0, acc} + s);
`ifdef VVMAC_SAT_EN
         if (n > {1'b0, {A{1'b1}}}) begin
            n     = {1'b0, {A{1'b1}}};
            r.sat = 1'b1;
         end
`endif
         r.dot = n[A-1:0];
      end
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < V; i++) v[i] = 16'($urandom);
      return v;
   endfunction

   function automatic beat_t mk_beat(input logic m, input logic c, input logic [I-1:0] av, input logic [I-1:0] xv);
      beat_t b;
      b.mode = m;
      b.clr  = c;
      for (int i = 0; i < V; i++) begin
         b.a[i] = av;
         b.x[i] = xv;
      end
      return b;
   endfunction

   // One clock: drive the next beat, log output pops and input pushes, advance.
   task automatic step(input logic rdy);
      beat_t b;
      res_t  r;
      @(negedge clk);
      bif.out_ready = rdy;
      if (stim_q.size() > 0) begin
         bif.in_valid  = 1'b1;
         bif.mode      = stim_q[0].mode;
         bif.acc_clear = stim_q[0].clr;
         bif.a         = stim_q[0].a;
         bif.x         = stim_q[0].x;
      end else begin
         bif.in_valid  = 1'b0;
         bif.mode      = 1'($urandom);
         bif.acc_clear = 1'($urandom);
         bif.a         = rand_vec();
         bif.x         = rand_vec();
      end
      #1;
      if (bif.out_valid && bif.out_ready) begin
         r.mode = bif.out_mode;
         r.y    = bif.y;
         r.dot  = bif.dot;
`ifdef VVMAC_SAT_EN
         r.sat  = bif.sat;
`else
         r.sat  = 1'b0;
`endif
         r.cyc  = cyc;
         obs_q.push_back(r);
      end
      if (bif.in_valid && bif.in_ready) begin
         b = stim_q.pop_front();
         r = predict(b, model_acc);
         if (b.mode) model_acc = r.dot;
         r.cyc = cyc;
         exp_q.push_back(r);
         accepted++;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic drain(input int n);
      int budget;
      budget = 400;
      while ((stim_q.size() > 0 || obs_q.size() < n) && budget > 0) begin
         step(1'b1);
         budget--;
      end
      checks++;
      if (obs_q.size() < n) begin
         errors++;
         $display("FAIL drain_timeout: got %0d results, need %0d", obs_q.size(), n);
      end
   endtask

   task automatic test_reset();
      res_t o;
      rst           = 1'b1;
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_handshake: out_valid=%0b in_ready=%0b, want 0 1", bif.out_valid, bif.in_ready);
      end
      checks++;
      if (bif.y !== '0 || bif.dot !== '0 || bif.out_mode !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: y=%h dot=%0d out_mode=%0b, want 0", bif.y, bif.dot, bif.out_mode);
      end
      // beats in flight, then reset
      stim_q.push_back(mk_beat(1'b1, 1'b1, 16'd3, 16'd5));
      stim_q.push_back(mk_beat(1'b1, 1'b0, 16'd3, 16'd5));
      stim_q.push_back(mk_beat(1'b1, 1'b0, 16'd3, 16'd5));
      step(1'b0);
      step(1'b0);
      @(negedge clk);
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b0;
      rst           = 1'b1;
      #1;
      checks++;
      if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_midflight: out_valid=%0b in_ready=%0b, want 0 1", bif.out_valid, bif.in_ready);
      end
      stim_q.delete();
      exp_q.delete();
      obs_q.delete();
      model_acc = '0;
      @(negedge clk);
      rst = 1'b0;
      // accumulate onto a cleared accumulator without acc_clear
      stim_q.push_back(mk_beat(1'b1, 1'b0, 16'd1, 16'd1));
      drain(1);
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         void'(exp_q.pop_front());
         checks++;
         if (o.dot !== 40'd16 || o.mode !== 1'b1) begin
            errors++;
            $display("FAIL reset_acc_cleared: dot=%0d mode=%0b, want 16 1", o.dot, o.mode);
         end
      end
   endtask

   task automatic test_elementwise();
      beat_t b;
      res_t  o, e;
      b = mk_beat(1'b0, 1'b0, 16'd0, 16'd0);
      b.a[0] = 16'd1; b.x[0] = 16'd4;
      b.a[1] = 16'd4; b.x[1] = 16'd2;
      stim_q.push_back(b);
      b = mk_beat(1'b0, 1'b0, 16'd0, 16'd0);
      b.a[3] = 16'hFFFF; b.x[3] = 16'd2;
      stim_q.push_back(b);
      b.mode = 1'b0; b.a = rand_vec(); b.x = rand_vec();
      stim_q.push_back(b);
      drain(3);
      if (obs_q.size() >= 2) begin
         checks++;
         if (obs_q[0].y[0] !== 16'd4 || obs_q[0].y[1] !== 16'd8 || obs_q[0].y[15:2] !== '0 || obs_q[0].dot !== '0) begin
            errors++;
            $display("FAIL ew_basic: y=%h dot=%0d, want lanes0/1 = 4/8 rest 0, dot 0", obs_q[0].y, obs_q[0].dot);
         end
         checks++;
`ifdef VVMAC_SAT_EN
         if (obs_q[1].y[3] !== 16'hFFFF || obs_q[1].sat !== 1'b1) begin
            errors++;
            $display("FAIL ew_sat: y3=%h sat=%0b, want FFFF 1", obs_q[1].y[3], obs_q[1].sat);
         end
`else
         if (obs_q[1].y[3] !== 16'hFFFE) begin
            errors++;
            $display("FAIL ew_wrap: y3=%h, want FFFE", obs_q[1].y[3]);
         end
`endif
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.mode !== e.mode || o.y !== e.y || o.dot !== e.dot || o.sat !== e.sat || (o.cyc - e.cyc) != 2) begin
            errors++;
            $display("FAIL ew_beat: got m=%0b y=%h dot=%0d sat=%0b lat=%0d want m=%0b y=%h dot=%0d sat=%0b lat=2",
                     o.mode, o.y, o.dot, o.sat, o.cyc - e.cyc, e.mode, e.y, e.dot, e.sat);
         end
      end
   endtask

   task automatic test_dot();
      res_t         o, e;
      logic [A-1:0] want[5];
      want[0] = 40'd240; want[1] = 40'd480; want[2] = 40'd0; want[3] = 40'd720; want[4] = 40'd240;
      stim_q.push_back(mk_beat(1'b1, 1'b1, 16'd3, 16'd5));
      stim_q.push_back(mk_beat(1'b1, 1'b0, 16'd3, 16'd5));
      stim_q.push_back(mk_beat(1'b0, 1'b1, 16'd3, 16'd5));
      stim_q.push_back(mk_beat(1'b1, 1'b0, 16'd3, 16'd5));
      stim_q.push_back(mk_beat(1'b1, 1'b1, 16'd3, 16'd5));
      drain(5);
      for (int k = 0; k < 5 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.dot !== want[k] || o.mode !== e.mode || o.y !== e.y || o.sat !== e.sat) begin
            errors++;
            $display("FAIL dot_seq[%0d]: got m=%0b dot=%0d y=%h want m=%0b dot=%0d y=%h",
                     k, o.mode, o.dot, o.y, e.mode, want[k], e.y);
         end
      end
   endtask

   task automatic test_backpressure();
      beat_t        b;
      res_t         o, e;
      vec_t         y_h;
      logic [A-1:0] dot_h;
      logic         m_h;
      int           n;
      accepted = 0;
      for (int k = 0; k < 5; k++) begin
         b.mode = 1'($urandom);
         b.clr  = (k == 0) ? 1'b1 : 1'($urandom);
         b.a    = rand_vec();
         b.x    = rand_vec();
         stim_q.push_back(b);
      end
      step(1'b0);
      step(1'b0);
      #1;
      y_h   = bif.y;
      dot_h = bif.dot;
      m_h   = bif.out_mode;
      checks++;
      if (bif.out_valid !== 1'b1 || exp_q.size() == 0 || m_h !== exp_q[0].mode || y_h !== exp_q[0].y || dot_h !== exp_q[0].dot) begin
         errors++;
         $display("FAIL bp_first_out: valid=%0b m=%0b dot=%0d y=%h", bif.out_valid, m_h, dot_h, y_h);
      end
      for (int k = 0; k < 2; k++) begin
         step(1'b0);
         #1;
         checks++;
         if (bif.out_valid !== 1'b1 || bif.y !== y_h || bif.dot !== dot_h || bif.out_mode !== m_h) begin
            errors++;
            $display("FAIL bp_hold: valid=%0b m=%0b dot=%0d y=%h, want held m=%0b dot=%0d y=%h",
                     bif.out_valid, bif.out_mode, bif.dot, bif.y, m_h, dot_h, y_h);
         end
      end
      checks++;
      if (accepted != 2 || bif.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_stall: accepted=%0d in_ready=%0b, want 2 0", accepted, bif.in_ready);
      end
      drain(5);
      n = 0;
      checks++;
      if (obs_q.size() != 5 || exp_q.size() != 5) begin
         errors++;
         $display("FAIL bp_count: got %0d results for %0d beats, want 5", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.mode !== e.mode || o.y !== e.y || o.dot !== e.dot || o.sat !== e.sat) begin
            errors++;
            $display("FAIL bp_beat[%0d]: got m=%0b dot=%0d y=%h want m=%0b dot=%0d y=%h", n, o.mode, o.dot, o.y, e.mode, e.dot, e.y);
         end
         n++;
      end
   endtask

   task automatic test_back_to_back();
      beat_t b;
      res_t  o, e;
      int    n;
      for (int k = 0; k < 10; k++) begin
         b.mode = 1'($urandom);
         b.clr  = (k == 0) ? 1'b1 : 1'($urandom);
         b.a    = rand_vec();
         b.x    = rand_vec();
         stim_q.push_back(b);
      end
      n = 0;
      while (stim_q.size() > 0 && n < 100) begin
         step(1'b1);
         n++;
      end
      checks++;
      if (n != 10) begin
         errors++;
         $display("FAIL b2b_throughput: 10 beats took %0d cycles, want 10", n);
      end
      // random consumer stalls with a continuous producer
      for (int k = 0; k < 30; k++) begin
         b.mode = 1'($urandom);
         b.clr  = 1'($urandom);
         b.a    = rand_vec();
         b.x    = rand_vec();
         stim_q.push_back(b);
      end
      n = 0;
      while (stim_q.size() > 0 && n < 400) begin
         step(1'($urandom));
         n++;
      end
      drain(40);
      n = 0;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.mode !== e.mode || o.y !== e.y || o.dot !== e.dot || o.sat !== e.sat) begin
            errors++;
            $display("FAIL b2b_beat[%0d]: got m=%0b dot=%0d y=%h want m=%0b dot=%0d y=%h", n, o.mode, o.dot, o.y, e.mode, e.dot, e.y);
         end
         n++;
      end
   endtask

   task automatic test_overflow();
      res_t o, e;
      for (int k = 0; k < 17; k++) begin
         stim_q.push_back(mk_beat(1'b1, (k == 0) ? 1'b1 : 1'b0, 16'hFFFF, 16'hFFFF));
      end
      drain(17);
      while (obs_q.size() > 1 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o.dot !== e.dot || o.sat !== e.sat || o.mode !== 1'b1) begin
            errors++;
            $display("FAIL ovf_beat: got dot=%0d sat=%0b want dot=%0d sat=%0b", o.dot, o.sat, e.dot, e.sat);
         end
      end
      if (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         checks++;
`ifdef VVMAC_SAT_EN
         if (o.dot !== {A{1'b1}} || o.sat !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sat: dot=%0d sat=%0b, want %0d 1", o.dot, o.sat, {A{1'b1}});
         end
`else
         if (o.dot !== 40'd68683825424) begin
            errors++;
            $display("FAIL ovf_wrap: dot=%0d, want 68683825424", o.dot);
         end
`endif
      end
      exp_q.delete();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      accepted      = 0;
      cyc           = 0;
      model_acc     = '0;
      rst           = 1'b1;
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b0;
      bif.mode      = 1'b0;
      bif.acc_clear = 1'b0;
      bif.a         = '0;
      bif.x         = '0;
      test_reset();
      test_elementwise();
      test_dot();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
